// File: rtl/texture_span_fetcher.sv
// Texture span fetcher: walks one texel row of the shared 64x64 texture ROM with a
// fixed-point column accumulator and streams the texels out through a 2-entry buffer.
module texture_span_fetcher #(
    parameter int unsigned FRAC_W = 4,
    parameter int unsigned LEN_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [5:0]          cmd_tex,
    input  logic [2:0]          cmd_v,
    input  logic [FRAC_W+2:0]   cmd_u0,
    input  logic [FRAC_W+2:0]   cmd_du,
    input  logic [LEN_W-1:0]    cmd_len,
    output logic [5:0]          rom_texture_idx,
    output logic [2:0]          rom_y_idx,
    output logic [2:0]          rom_x_idx,
    input  logic [2:0]          rom_val,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [2:0]          pix_data,
    output logic                pix_last,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [5:0]           r_tex;
    logic [2:0]           r_v;
    logic [FRAC_W+2:0]    r_u;
    logic [FRAC_W+2:0]    r_du;
    logic [LEN_W-1:0]     r_rem;
    logic                 r_in_flight;
    logic                 r_last_flight;
    logic                 r_done;

    logic [2:0]           r_fifo_data [2];
    logic                 r_fifo_last [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;

    logic                 w_accept;
    logic                 w_fire;
    logic                 w_push;
    logic                 w_pop;
    logic [2:0]           w_credit;
    logic                 w_span_end;

    assign w_push   = r_in_flight;
    assign w_pop    = pix_valid & pix_ready;
    assign w_credit = {1'b0, r_count} + {2'b00, r_in_flight} - {2'b00, w_pop};

    // Leave DRAIN on the edge that empties the buffer, so done and cmd_ready
    // appear together in the cycle right after the final handshake.
    assign w_span_end = (r_state == S_DRAIN) && !r_in_flight &&
                        ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        w_accept     = 1'b0;
        w_fire       = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    if (cmd_len != '0) begin
                        w_state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if ((r_rem != '0) && (w_credit < 3'd2)) begin
                    w_fire = 1'b1;
                    if (r_rem == LEN_W'(1)) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_span_end) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tex         <= '0;
            r_v           <= '0;
            r_u           <= '0;
            r_du          <= '0;
            r_rem         <= '0;
            r_in_flight   <= 1'b0;
            r_last_flight <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_in_flight <= w_fire;
            r_done      <= (w_accept && (cmd_len == '0)) || w_span_end;
            if (w_accept) begin
                r_tex <= cmd_tex;
                r_v   <= cmd_v;
                r_u   <= cmd_u0;
                r_du  <= cmd_du;
                r_rem <= cmd_len;
            end else if (w_fire) begin
                r_u           <= r_u + r_du;
                r_rem         <= r_rem - LEN_W'(1);
                r_last_flight <= (r_rem == LEN_W'(1));
            end
        end
    end

    // Issue credit guarantees at most one entry is held whenever a capture lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_last[i] <= 1'b0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= rom_val;
                r_fifo_last[r_wr_ptr] <= r_last_flight;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rom_texture_idx = r_tex;
    assign rom_y_idx       = r_v;
    assign rom_x_idx       = r_u[FRAC_W+2:FRAC_W];

    assign pix_valid = (r_count != 2'd0);
    assign pix_data  = r_fifo_data[r_rd_ptr];
    assign pix_last  = r_fifo_last[r_rd_ptr];
    assign done      = r_done;

endmodule

// File: tb/tb_texture_span_fetcher.sv
// Self-checking bench for texture_span_fetcher: ROM model returns the column index,
// expected texels are queued when a command is issued and compared against the stream.
module tb_texture_span_fetcher;

    localparam int unsigned FRAC_W = 4;
    localparam int unsigned LEN_W  = 8;

    logic                clk;
    logic                reset;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [5:0]          cmd_tex;
    logic [2:0]          cmd_v;
    logic [FRAC_W+2:0]   cmd_u0;
    logic [FRAC_W+2:0]   cmd_du;
    logic [LEN_W-1:0]    cmd_len;
    logic [5:0]          rom_texture_idx;
    logic [2:0]          rom_y_idx;
    logic [2:0]          rom_x_idx;
    logic [2:0]          rom_val;
    logic                pix_valid;
    logic                pix_ready;
    logic [2:0]          pix_data;
    logic                pix_last;
    logic                done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exp_q [$];
    logic [3:0] obs_q [$];
    int first_valid, last_cycle, done_cycle, done_count, stall_err, rom_err;

    texture_span_fetcher #(.FRAC_W(FRAC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_tex(cmd_tex), .cmd_v(cmd_v), .cmd_u0(cmd_u0), .cmd_du(cmd_du), .cmd_len(cmd_len),
        .rom_texture_idx(rom_texture_idx), .rom_y_idx(rom_y_idx), .rom_x_idx(rom_x_idx),
        .rom_val(rom_val),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM: data is the column index of the previous cycle's address.
    always @(posedge clk) rom_val <= rom_x_idx;

    function automatic void push_expected(input logic [6:0] u0, input logic [6:0] du, input int len);
        logic [6:0] u;
        u = u0;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({u[6:4], (i == len - 1) ? 1'b1 : 1'b0});
            u = u + du;
        end
    endfunction

    function automatic logic rdy_of(input int mode, input int i);
        if (mode == 0) return 1'b1;
        return ((i % 6) == 0) || ((i % 6) == 3) || ((i % 6) == 5);
    endfunction

    // Issues one command and records the resulting stream; cycle 0 is the cycle after accept.
    task automatic run_span(input logic [5:0] tex, input logic [2:0] v, input logic [6:0] u0,
                            input logic [6:0] du, input logic [7:0] len, input int mode, input int budget);
        bit prev_stall;
        logic [3:0] prev;
        int w;
        obs_q.delete();
        first_valid = -1; last_cycle = -1; done_cycle = -1;
        done_count = 0; stall_err = 0; rom_err = 0;
        prev_stall = 1'b0; prev = '0;
        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < budget) begin
            @(negedge clk);
            w++;
        end
        cmd_valid = 1'b1; cmd_tex = tex; cmd_v = v; cmd_u0 = u0; cmd_du = du; cmd_len = len;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        pix_ready = rdy_of(mode, 0);
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (pix_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall && (!pix_valid || {pix_data, pix_last} != prev)) stall_err++;
            prev_stall = pix_valid && !pix_ready;
            prev = {pix_data, pix_last};
            if (pix_valid && pix_ready) begin
                obs_q.push_back({pix_data, pix_last});
                if (pix_last) last_cycle = cyc;
            end
            if (done_count == 0 && (rom_texture_idx != tex || rom_y_idx != v)) rom_err++;
            if (done) begin
                if (done_count == 0) done_cycle = cyc;
                done_count++;
            end
            if (done_count > 0 && cyc >= done_cycle + 2) break;
            @(posedge clk);
            #1;
            pix_ready = rdy_of(mode, cyc + 1);
        end
        pix_ready = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; cmd_valid = 1'b0; pix_ready = 1'b1;
        cmd_tex = '0; cmd_v = '0; cmd_u0 = '0; cmd_du = '0; cmd_len = '0;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if ({cmd_ready, pix_valid, pix_data, pix_last, done} !== 7'b1_0_000_0_0)
            $display("FAIL reset_outputs: got rdy=%b vld=%b data=%0d last=%b done=%b, want 1 0 0 0 0",
                     cmd_ready, pix_valid, pix_data, pix_last, done);
        n_checks++;
        if ({rom_texture_idx, rom_y_idx, rom_x_idx} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_rom: got %h, want 000", {rom_texture_idx, rom_y_idx, rom_x_idx});
        end
        if ({cmd_ready, pix_valid, pix_data, pix_last, done} !== 7'b1_0_000_0_0) n_fail++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        logic [3:0] e, o;
        push_expected(7'h00, 7'h10, 4);
        run_span(6'd9, 3'd3, 7'h00, 7'h10, 8'd4, 0, 40);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d texels, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 4'hx;
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL basic_texel: got data=%0d last=%b, want data=%0d last=%b", o[3:1], o[0], e[3:1], e[0]);
            end
        end
        n_checks++;
        if (first_valid != 2) begin
            n_fail++;
            $display("FAIL basic_latency: first pix_valid at cycle %0d, want 2", first_valid);
        end
        n_checks++;
        if (last_cycle != 5) begin
            n_fail++;
            $display("FAIL basic_last_cycle: pix_last at cycle %0d, want 5", last_cycle);
        end
        n_checks++;
        if (done_cycle != 6 || done_count != 1) begin
            n_fail++;
            $display("FAIL basic_done: done at cycle %0d count %0d, want cycle 6 count 1", done_cycle, done_count);
        end
        n_checks++;
        if (rom_err != 0) begin
            n_fail++;
            $display("FAIL basic_rom_idx: %0d cycles with wrong tex/row, want 0", rom_err);
        end
    endtask

    task automatic test_wrap_and_fraction;
        logic [3:0] e, o;
        logic [6:0] u0s [3] = '{7'h60, 7'h00, 7'h00};
        logic [6:0] dus [3] = '{7'h10, 7'h08, 7'h28};
        int         lens [3] = '{5, 6, 4};
        for (int k = 0; k < 3; k++) begin
            push_expected(u0s[k], dus[k], lens[k]);
            run_span(6'd37, 3'd6, u0s[k], dus[k], 8'(lens[k]), 0, 40);
            n_checks++;
            if (obs_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL step%0d_count: got %0d texels, want %0d", k, obs_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = (obs_q.size() > 0) ? obs_q.pop_front() : 4'hx;
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL step%0d_texel: got data=%0d last=%b, want data=%0d last=%b", k, o[3:1], o[0], e[3:1], e[0]);
                end
            end
            n_checks++;
            if (rom_err != 0 || done_count != 1) begin
                n_fail++;
                $display("FAIL step%0d_span: rom_err=%0d done_count=%0d, want 0 and 1", k, rom_err, done_count);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [3:0] e, o;
        push_expected(7'h00, 7'h10, 8);
        run_span(6'd2, 3'd1, 7'h00, 7'h10, 8'd8, 1, 80);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL bp_count: got %0d texels, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 4'hx;
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL bp_texel: got data=%0d last=%b, want data=%0d last=%b", o[3:1], o[0], e[3:1], e[0]);
            end
        end
        n_checks++;
        if (stall_err != 0) begin
            n_fail++;
            $display("FAIL bp_stable: %0d stalled cycles changed the head, want 0", stall_err);
        end
        n_checks++;
        if (done_count != 1 || done_cycle != last_cycle + 1) begin
            n_fail++;
            $display("FAIL bp_done: done at %0d count %0d, want at %0d count 1", done_cycle, done_count, last_cycle + 1);
        end
    endtask

    task automatic test_zero_len;
        logic [3:0] e, o;
        run_span(6'd5, 3'd2, 7'h30, 7'h10, 8'd0, 0, 20);
        n_checks++;
        if (first_valid != -1 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL zero_len_pix: pix_valid at %0d with %0d texels, want none", first_valid, obs_q.size());
        end
        n_checks++;
        if (done_cycle != 0 || done_count != 1) begin
            n_fail++;
            $display("FAIL zero_len_done: done at %0d count %0d, want cycle 0 count 1", done_cycle, done_count);
        end
        push_expected(7'h30, 7'h10, 1);
        run_span(6'd5, 3'd2, 7'h30, 7'h10, 8'd1, 0, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 4'hx;
            n_checks++;
            if (o !== e || first_valid != 2) begin
                n_fail++;
                $display("FAIL zero_len_next: got data=%0d last=%b at %0d, want data=%0d last=%b at 2",
                         o[3:1], o[0], first_valid, e[3:1], e[0]);
            end
        end
    endtask

    task automatic test_async_reset;
        logic [3:0] e, o;
        int hs, dn;
        hs = 0; dn = 0;
        @(negedge clk);
        pix_ready = 1'b1;
        cmd_valid = 1'b1; cmd_tex = 6'd12; cmd_v = 3'd4; cmd_u0 = 7'h10; cmd_du = 7'h10; cmd_len = 8'd8;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 30 && hs < 3; cyc++) begin
            @(negedge clk);
            if (pix_valid && pix_ready) hs++;
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({cmd_ready, pix_valid, pix_data, pix_last, done} !== 7'b1_0_000_0_0 ||
            {rom_texture_idx, rom_y_idx, rom_x_idx} !== 12'h000) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got rdy=%b vld=%b data=%0d last=%b done=%b rom=%h, want 1 0 0 0 0 000",
                     cmd_ready, pix_valid, pix_data, pix_last, done, {rom_texture_idx, rom_y_idx, rom_x_idx});
        end
        repeat (2) begin
            @(negedge clk);
            if (done) dn++;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || pix_valid) dn++;
        end
        n_checks++;
        if (dn != 0 || hs != 3) begin
            n_fail++;
            $display("FAIL async_reset_quiet: %0d stray done/valid cycles after %0d handshakes, want 0 after 3", dn, hs);
        end
        push_expected(7'h50, 7'h10, 2);
        run_span(6'd12, 3'd4, 7'h50, 7'h10, 8'd2, 0, 20);
        n_checks++;
        if (obs_q.size() != 2) begin
            n_fail++;
            $display("FAIL post_reset_count: got %0d texels, want 2", obs_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 4'hx;
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL post_reset_texel: got data=%0d last=%b, want data=%0d last=%b", o[3:1], o[0], e[3:1], e[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_and_fraction();
        test_backpressure();
        test_zero_len();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/texture_span_fetcher.md
Name: texture_span_fetcher

Overview:
- Sequences the shared 64x64 texture ROM (8x8 textures of 8x8 texels, 3-bit texels, 1-cycle registered read) to produce one horizontal span of texels per command.
- Accepts a span command: texture, row, fixed-point start column, step and length. Steps the column accumulator per texel, issues one ROM read per cycle, and delivers texels on a ready/valid stream with backpressure.
- Sits between the VGA span renderer (command side) and the pixel output path.

Parameters:
- FRAC_W, 4, fractional bits of column accumulator/step (u is 3.FRAC_W, unsigned)
- LEN_W, 8, width of span length field

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  span command present
- cmd_ready  out  1  block can accept command
- cmd_tex  in  6  texture index
- cmd_v  in  3  texel row within texture
- cmd_u0  in  3+FRAC_W  start column, 3.FRAC_W fixed point
- cmd_du  in  3+FRAC_W  column step per texel, 3.FRAC_W
- cmd_len  in  LEN_W  texel count (0 legal)
- rom_texture_idx  out  6  to ROM texture_idx
- rom_y_idx  out  3  to ROM y_idx
- rom_x_idx  out  3  to ROM x_idx
- rom_val  in  3  ROM data, valid 1 cycle after address
- pix_valid  out  1  texel available
- pix_ready  in  1  consumer accepts texel
- pix_data  out  3  texel value
- pix_last  out  1  marks final texel of span
- done  out  1  one-cycle pulse, span complete

Behaviour:
- Reset (async, any time including mid-span): state IDLE; FIFO empty; in-flight flag clear; latched tex/v/u = 0; remaining = 0. Outputs: cmd_ready=1, pix_valid=0, pix_data=0, pix_last=0, done=0, rom_* = 0. Any partial span is discarded.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - cmd_ready=1. On cmd_valid, latch tex, v, u=cmd_u0, du, remaining=cmd_len.
  - Go to RUN if cmd_len!=0. If cmd_len==0, pulse done the next cycle, emit no texels, stay IDLE.
- RUN/DRAIN: cmd_ready=0.
- ROM addressing:
  - rom_texture_idx and rom_y_idx are driven from the latched tex and v.
  - rom_x_idx = u[FRAC_W+2:FRAC_W]. Column wraps mod 8 inside the texture, never into a neighbour.
  - u accumulates modulo 2^(3+FRAC_W); no saturation.
- Output buffer:
  - 2-entry FIFO of {data, last}.
  - credit = FIFO count + in_flight − (pix_valid & pix_ready).
- Issue (RUN only):
  - Fires when remaining>0 and credit<2.
  - On fire: in_flight<=1; last_flight<=(remaining==1); u<=u+du; remaining<=remaining−1.
  - Address is presented in the fire cycle.
  - Firing the final texel moves to DRAIN.
- Capture: the cycle after a fire, rom_val and last_flight are pushed into the FIFO. in_flight clears unless a new fire occurs.
- Output:
  - pix_valid = FIFO non-empty; pix_data/pix_last come from the FIFO head.
  - Head holds stable while pix_valid & !pix_ready.
  - A push and a pop in the same cycle are both honoured.
- Latency and throughput:
  - First texel: pix_valid rises 2 cycles after the command-accept edge (1 issue + 1 ROM).
  - With pix_ready held high, one texel per cycle sustained.
- DRAIN → IDLE when FIFO empty and !in_flight, i.e. the cycle after the pix_last handshake. done pulses for 1 cycle on that transition; cmd_ready=1 the same cycle.
- pix_last is asserted on exactly one texel per nonzero-length span.
- Commands are never accepted while RUN/DRAIN.

Test Plan:
- Bench ROM model returns val = x_idx.
- Basic span: tex=9, v=3, u0=0, du=1.0 (0x10), len=4, pix_ready=1 → rom_texture_idx=9, rom_y_idx=3; pix_data 0,1,2,3 on consecutive cycles; pix_last on the 4th texel; done one cycle after it; first pix_valid 2 cycles after accept.
- Wrap: u0=6.0, du=1.0, len=5 → pix_data 6,7,0,1,2; rom_texture_idx stays constant.
- Fractional step: u0=0, du=0.5 (0x08), len=6 → 0,0,1,1,2,2. Also du=2.5 (0x28) from 0, len=4 → 0,2,5,7.
- Backpressure: len=8, du=1.0, pix_ready toggled 1,0,0,1,0,1... → all 8 texels 0..7 delivered in order, none lost or duplicated; pix_data stable while stalled; FIFO never exceeds 2.
- len=0 command → no pix_valid; done pulses once the cycle after accept; next command accepted immediately.
- Async reset asserted mid-span (after 3 of 8 texels), between clock edges → outputs go to reset values immediately; no done pulse. After release, a new span len=2 produces exactly 2 correct texels with pix_last on the 2nd.
